// File: rtl/v35_intc.sv
// External interrupt controller for the V35 core: synchronised active-low pins,
// per-channel mask/mode/priority, nested in-service tracking and vectored acknowledge.
module v35_intc #(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [NUM_CH-1:0] n_intp,
  input  logic              reg_wr,
  input  logic [3:0]        reg_addr,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  output logic              irq_req,
  input  logic              irq_ack,
  output logic [7:0]        irq_vector,
  input  logic              eoi
);

  logic [NUM_CH-1:0] sync [SYNC_STAGES];
  logic [NUM_CH-1:0] mask, mode, latch, in_service;
  logic [2:0]        prio [NUM_CH];
  logic [7:0]        vec_base;

  logic [NUM_CH-1:0] fall, request, eligible, win_oh, eoi_oh, wr_ch, wr_clr, clr;
  logic [2:0]        win_idx, win_prio, top_prio;
  logic              any_elig, any_is, ack_taken, ack_go, eoi_go, wr_vec;

  // Pin synchroniser, idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '1;
    end else if (ce) begin
      sync[0] <= n_intp;
      for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
    end
  end

  // The falling edge is seen one stage early so the latch sets together with the last stage
  assign fall    = sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES-2];
  assign request = (mode & ~sync[SYNC_STAGES-1]) | (~mode & latch);

  always_comb begin
    any_is   = 1'b0;
    top_prio = 3'd7;
    eoi_oh   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_service[i] && (!any_is || prio[i] < top_prio)) begin
        any_is   = 1'b1;
        top_prio = prio[i];
        eoi_oh   = '0;
        eoi_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      eligible[i] = request[i] & ~mask[i] & (!any_is || prio[i] < top_prio);
  end

  // Lowest priority value wins; strict compare keeps the lowest index on ties
  always_comb begin
    any_elig = 1'b0;
    win_prio = 3'd7;
    win_idx  = '0;
    win_oh   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (eligible[i] && (!any_elig || prio[i] < win_prio)) begin
        any_elig = 1'b1;
        win_prio = prio[i];
        win_idx  = 3'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      win_oh[i] = any_elig && (win_idx == 3'(i));
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ch[i]  = reg_wr && (reg_addr == 4'(i));
      wr_clr[i] = wr_ch[i] && reg_wdata[5];
    end
  end

  assign wr_vec    = reg_wr && (reg_addr == 4'(NUM_CH));
  assign ack_taken = irq_ack & irq_req;
  assign ack_go    = ack_taken & any_elig;
  assign eoi_go    = eoi & any_is;
  assign clr       = (ack_go ? win_oh : '0) | wr_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask     <= '1;
      mode     <= '0;
      vec_base <= '0;
      for (int i = 0; i < NUM_CH; i++) prio[i] <= 3'd7;
    end else if (ce) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ch[i]) begin
          mask[i] <= reg_wdata[0];
          mode[i] <= reg_wdata[1];
          prio[i] <= reg_wdata[4:2];
        end
      end
      if (wr_vec) vec_base <= reg_wdata;
    end
  end

  // A new edge beats a same-cycle clear; level mode keeps the latch empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch      <= '0;
      in_service <= '0;
      irq_req    <= 1'b0;
      irq_vector <= '0;
    end else if (ce) begin
      latch      <= ~mode & ((latch & ~clr) | fall);
      in_service <= (in_service & ~(eoi_go ? eoi_oh : '0)) | (ack_go ? win_oh : '0);
      irq_req    <= ack_taken ? 1'b0 : any_elig;
      if (ack_go) irq_vector <= vec_base + {5'd0, win_idx};
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (reg_addr == 4'(i))
        reg_rdata = {in_service[i], request[i], 1'b0, prio[i], mode[i], mask[i]};
    end
    if (reg_addr == 4'(NUM_CH)) reg_rdata = vec_base;
  end

endmodule

// File: tb/tb_v35_intc.sv
// Directed bench for v35_intc: stimulus queues expected values, a negedge monitor
// compares them and checks irq_vector after every accepted acknowledge.
module tb_v35_intc;
  localparam int NUM_CH = 3;

  logic              clk = 1'b0;
  logic              reset, ce;
  logic [NUM_CH-1:0] n_intp;
  logic              reg_wr;
  logic [3:0]        reg_addr;
  logic [7:0]        reg_wdata, reg_rdata;
  logic              irq_req, irq_ack, eoi;
  logic [7:0]        irq_vector;

  v35_intc #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ce(ce), .n_intp(n_intp),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .irq_req(irq_req), .irq_ack(irq_ack), .irq_vector(irq_vector), .eoi(eoi)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } chk_t;

  chk_t       cq[$];
  logic [7:0] vq[$];
  int         tests = 0;
  int         fails = 0;
  logic       ack_seen = 1'b0;
  chk_t       cur;
  logic [7:0] act, vexp;

  always @(posedge clk) ack_seen <= ce && irq_ack && irq_req && !reset;

  // sel: 0 irq_req, 1 irq_vector, 2 reg_rdata, 3 outstanding vector expectations
  always @(negedge clk) begin
    while (cq.size() > 0) begin
      cur = cq.pop_front();
      case (cur.sel)
        0:       act = {7'd0, irq_req};
        1:       act = irq_vector;
        2:       act = reg_rdata;
        default: act = 8'(vq.size());
      endcase
      tests++;
      if (act !== cur.exp) begin
        fails++;
        $display("FAIL %s: got %02h, expected %02h", cur.name, act, cur.exp);
      end
    end
    if (ack_seen) begin
      tests++;
      if (vq.size() == 0) begin
        fails++;
        $display("FAIL ack_vector: unexpected acknowledge, vector %02h", irq_vector);
      end else begin
        vexp = vq.pop_front();
        if (irq_vector !== vexp) begin
          fails++;
          $display("FAIL ack_vector: got %02h, expected %02h", irq_vector, vexp);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int sel, input logic [7:0] e);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = e;
    cq.push_back(c);
  endtask

  task automatic req_is(input string nm, input logic e);
    chk(nm, 0, {7'd0, e});
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
    reg_addr = a;
    chk(nm, 2, e);
    step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    step();
    reg_wr = 1'b0;
  endtask

  task automatic ack(input logic [7:0] v);
    vq.push_back(v);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; n_intp = '1; reg_wr = 1'b0; reg_addr = '0;
    reg_wdata = '0; irq_ack = 1'b0; eoi = 1'b0;
    step(2);
    reset = 1'b0;

    // Reset state
    req_is("rst_req", 1'b0);
    chk("rst_vector", 1, 8'h00);
    rd(4'd0, 8'h1D, "rst_ch0");
    rd(4'd2, 8'h1D, "rst_ch2");
    rd(4'd3, 8'h00, "rst_vbase");
    rd(4'd5, 8'h00, "rst_other_addr");

    // Ch1 edge, prio 3, vector base 0x40
    wr(4'd3, 8'h40);
    wr(4'd1, 8'h0C);
    rd(4'd1, 8'h0C, "t1_ch1_cfg");
    rd(4'd3, 8'h40, "t1_vbase");
    n_intp[1] = 1'b0;
    step(); req_is("t1_req_a", 1'b0);
    step(); req_is("t1_req_b", 1'b0);
    rd(4'd1, 8'h4C, "t1_ch1_pending");
    req_is("t1_req_c", 1'b1);
    ack(8'h41);
    req_is("t1_req_after_ack", 1'b0);
    rd(4'd1, 8'h8C, "t1_ch1_inservice");
    req_is("t1_req_stays_low", 1'b0);
    n_intp[1] = 1'b1;
    pulse_eoi();
    rd(4'd1, 8'h0C, "t1_ch1_after_eoi");

    // Two pending: ch0 prio 5, ch2 prio 2
    wr(4'd0, 8'h14);
    wr(4'd2, 8'h08);
    n_intp[0] = 1'b0; n_intp[2] = 1'b0;
    step(2); req_is("t2_req_early", 1'b0);
    step();  req_is("t2_req", 1'b1);
    ack(8'h42);
    req_is("t2_req_after_ack", 1'b0);
    rd(4'd0, 8'h54, "t2_ch0_pending");
    req_is("t2_ch0_blocked", 1'b0);
    rd(4'd2, 8'h88, "t2_ch2_inservice");
    pulse_eoi();
    req_is("t2_req_at_eoi", 1'b0);
    step();
    req_is("t2_req_ch0", 1'b1);
    ack(8'h40);
    req_is("t2_req_after_ack0", 1'b0);
    rd(4'd0, 8'h94, "t2_ch0_inservice");
    pulse_eoi();
    n_intp[0] = 1'b1; n_intp[2] = 1'b1;
    step();
    rd(4'd0, 8'h14, "t2_ch0_idle");

    // Nesting: ch0 prio 4 in service, ch2 prio 4 blocked, ch1 prio 1 nests
    wr(4'd0, 8'h10);
    wr(4'd2, 8'h10);
    wr(4'd1, 8'h04);
    n_intp[0] = 1'b0;
    step(3); req_is("t3_req_ch0", 1'b1);
    ack(8'h40);
    n_intp[0] = 1'b1;
    n_intp[2] = 1'b0;
    step(3); req_is("t3_ch2_equal_prio", 1'b0);
    rd(4'd2, 8'h50, "t3_ch2_pending");
    req_is("t3_ch2_still_blocked", 1'b0);
    n_intp[1] = 1'b0;
    step(3); req_is("t3_req_ch1", 1'b1);
    ack(8'h41);
    req_is("t3_req_after_ack", 1'b0);
    pulse_eoi();
    rd(4'd1, 8'h04, "t3_eoi1_ch1");
    rd(4'd0, 8'h90, "t3_eoi1_ch0");
    req_is("t3_req_between_eoi", 1'b0);
    pulse_eoi();
    rd(4'd0, 8'h10, "t3_eoi2_ch0");
    req_is("t3_req_ch2_released", 1'b1);
    ack(8'h42);
    pulse_eoi();
    n_intp[1] = 1'b1; n_intp[2] = 1'b1;
    step();
    req_is("t3_idle", 1'b0);

    // Level mode on ch2, prio 2
    wr(4'd2, 8'h0A);
    n_intp[2] = 1'b0;
    step(2); req_is("t4_req_early", 1'b0);
    step();  req_is("t4_req", 1'b1);
    ack(8'h42);
    req_is("t4_req_after_ack", 1'b0);
    rd(4'd2, 8'hCA, "t4_ch2_level_inservice");
    req_is("t4_req_inservice", 1'b0);
    pulse_eoi();
    req_is("t4_req_at_eoi", 1'b0);
    step();
    req_is("t4_req_reassert", 1'b1);
    n_intp[2] = 1'b1;
    step(); req_is("t4_release_a", 1'b1);
    step(); req_is("t4_release_b", 1'b1);
    step(); req_is("t4_release_drop", 1'b0);
    wr(4'd2, 8'h08);
    step();
    req_is("t4_edge_mode_quiet", 1'b0);
    rd(4'd2, 8'h08, "t4_ch2_edge_cfg");

    // Edge coinciding with a clear write, then mask/unmask
    n_intp[1] = 1'b0;
    step();
    wr(4'd1, 8'h24);
    rd(4'd1, 8'h44, "t5_edge_beats_clear");
    req_is("t5_req", 1'b1);
    wr(4'd1, 8'h05);
    req_is("t5_req_write_cycle", 1'b1);
    rd(4'd1, 8'h45, "t5_masked_keeps_req");
    req_is("t5_masked", 1'b0);
    wr(4'd1, 8'h04);
    req_is("t5_unmask_write_cycle", 1'b0);
    step();
    req_is("t5_unmasked", 1'b1);
    ack(8'h41);
    pulse_eoi();
    n_intp[1] = 1'b1;
    step(2);
    n_intp[1] = 1'b0;
    step(2);
    wr(4'd1, 8'h05);
    wr(4'd1, 8'h25);
    rd(4'd1, 8'h05, "t5_clear_write");
    wr(4'd1, 8'h04);
    step();
    req_is("t5_cleared_no_req", 1'b0);
    n_intp[1] = 1'b1;
    step();

    // Clock enable held low across the pin edge
    ce = 1'b0;
    n_intp[0] = 1'b0;
    step(4);
    req_is("t6_ce_low", 1'b0);
    rd(4'd0, 8'h10, "t6_ce_low_no_req");
    ce = 1'b1;
    step(); req_is("t6_a", 1'b0);
    step(); req_is("t6_b", 1'b0);
    step(); req_is("t6_c", 1'b1);
    ack(8'h40);
    step(2);
    req_is("t6_once", 1'b0);
    rd(4'd0, 8'h90, "t6_ch0_inservice");
    pulse_eoi();

    // Asynchronous reset in the middle of an acknowledge cycle
    n_intp[2] = 1'b0;
    step(3);
    req_is("t7_req", 1'b1);
    step();
    irq_ack = 1'b1;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    irq_ack = 1'b0;
    req_is("t7_req_reset", 1'b0);
    chk("t7_vector_reset", 1, 8'h00);
    rd(4'd0, 8'h1D, "t7_ch0_reset");
    rd(4'd3, 8'h00, "t7_vbase_reset");
    chk("vq_drained", 3, 8'h00);
    step();
    n_intp = '1;
    step(3);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
